// File: rtl/conv_host_pkg.sv
// Shared types and size helpers for the convolution host slice.
package conv_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_SEND  = 3'd2,
        ST_RECV  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Number of results produced by a valid-mode convolution.
    function automatic int unsigned calc_l(input int unsigned n, input int unsigned m);
        return n - m + 32'd1;
    endfunction

    // Address width for a memory of the given depth (at least one bit).
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth <= 32'd1) ? 32'd1 : 32'($clog2(depth));
    endfunction

endpackage

// File: rtl/conv_frame_host_if.sv
// x (sample) and y (result) stream channels between the host and a convolution block.
interface conv_frame_host_if #(
    parameter int unsigned T = 16
);
    logic [T-1:0] x_data;
    logic         x_valid;
    logic         x_ready;
    logic [T-1:0] y_data;
    logic         y_valid;
    logic         y_ready;
    logic         y_hold;

    modport master (
        output x_data, x_valid, y_ready,
        input  x_ready, y_data, y_valid, y_hold
    );

    modport slave (
        input  x_data, x_valid, y_ready,
        output x_ready, y_data, y_valid, y_hold
    );
endinterface

// File: rtl/conv_buf_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port, old data on collision.
module conv_buf_ram
    import conv_host_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 96,
    localparam int unsigned AW   = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    // Out-of-range reads return zero rather than an undefined array element.
    always_comb begin
        rdata_d = '0;
        if (32'(raddr) < DEPTH) begin
            rdata_d = mem_q[raddr];
        end
    end

    // Storage and read register; the read sees the array before this edge's write.
    always_ff @(posedge clk) begin
        if (we && (32'(waddr) < DEPTH)) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/conv_frame_host.sv
// Host initiator: buffers one input frame, streams it to a convolution block and
// collects the returned results into a randomly readable result buffer.
module conv_frame_host
    import conv_host_pkg::*;
#(
    parameter int unsigned N    = 96,
    parameter int unsigned M    = 65,
    parameter int unsigned T    = 16,
    localparam int unsigned L   = calc_l(N, M),
    localparam int unsigned IAW = addr_w(N),
    localparam int unsigned RAW = addr_w(L)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_we,
    input  logic [IAW-1:0]    in_addr,
    input  logic [T-1:0]      in_wdata,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [RAW-1:0]    res_addr,
    output logic [T-1:0]      res_rdata,
    conv_frame_host_if.master xy
);

    localparam int unsigned XCW = IAW + 1;
    localparam int unsigned YCW = RAW + 1;

    state_e         state_q, state_d;
    logic [XCW-1:0] xcnt_q, xcnt_d;
    logic [YCW-1:0] ycnt_q, ycnt_d;
    logic           err_q, err_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           x_valid_q, x_valid_d;

    logic           idle_or_done;
    logic           x_fire;
    logic           y_fire;
    logic           y_ready_c;
    logic           res_we;
    logic           in_wr_en;
    logic [IAW-1:0] in_raddr;
    logic [T-1:0]   in_rdata;

    // Next-state, counters, read address and flag updates.
    always_comb begin
        state_d   = state_q;
        xcnt_d    = xcnt_q;
        ycnt_d    = ycnt_q;
        err_d     = err_q;
        in_raddr  = '0;

        idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
        in_wr_en     = in_we && idle_or_done;
        y_ready_c    = ((state_q == ST_SEND) || (state_q == ST_RECV)) && !xy.y_hold;
        x_fire       = x_valid_q && xy.x_ready;
        y_fire       = xy.y_valid && y_ready_c;
        res_we       = y_fire && (32'(ycnt_q) < L);

        if (res_we) begin
            ycnt_d = ycnt_q + YCW'(1);
        end

        // A result offered while no frame is streaming is a protocol error.
        if (xy.y_valid && (idle_or_done || (state_q == ST_PRIME))) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_PRIME;
                    xcnt_d  = '0;
                    ycnt_d  = '0;
                    err_d   = 1'b0;
                end
            end
            ST_PRIME: begin
                state_d = ST_SEND;
            end
            ST_SEND: begin
                // Look ahead one word on a fire so the stream has no bubbles.
                in_raddr = IAW'(xcnt_q);
                if (x_fire) begin
                    xcnt_d = xcnt_q + XCW'(1);
                    if (xcnt_q == XCW'(N - 1)) begin
                        state_d = ST_RECV;
                    end else begin
                        in_raddr = IAW'(xcnt_q + XCW'(1));
                    end
                end
            end
            ST_RECV: begin
                if ((y_fire && (ycnt_q == YCW'(L - 1))) || (ycnt_q == YCW'(L))) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d    = (state_d == ST_PRIME) || (state_d == ST_SEND) || (state_d == ST_RECV);
        done_d    = (state_d == ST_DONE);
        x_valid_d = (state_d == ST_SEND);
    end

    // State, counters and registered status outputs; reset aborts any frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            xcnt_q    <= '0;
            ycnt_q    <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            x_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            xcnt_q    <= xcnt_d;
            ycnt_q    <= ycnt_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            x_valid_q <= x_valid_d;
        end
    end

    conv_buf_ram #(
        .WIDTH (T),
        .DEPTH (N)
    ) u_in_buf (
        .clk   (clk),
        .we    (in_wr_en),
        .waddr (in_addr),
        .wdata (in_wdata),
        .raddr (in_raddr),
        .rdata (in_rdata)
    );

    conv_buf_ram #(
        .WIDTH (T),
        .DEPTH (L)
    ) u_res_buf (
        .clk   (clk),
        .we    (res_we),
        .waddr (RAW'(ycnt_q)),
        .wdata (xy.y_data),
        .raddr (res_addr),
        .rdata (res_rdata)
    );

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign xy.x_valid = x_valid_q;
    assign xy.x_data  = in_rdata;
    assign xy.y_ready = y_ready_c;

endmodule

// File: tb/tb_conv_frame_host.sv
// Randomized frame-level bench for conv_frame_host against a transaction model.
module tb_conv_frame_host;

    localparam int unsigned N   = 96;
    localparam int unsigned M   = 65;
    localparam int unsigned T   = 16;
    localparam int unsigned L   = N - M + 1;
    localparam int unsigned IAW = 7;
    localparam int unsigned RAW = 5;
    localparam int          BUDGET = 3000;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_we;
    logic [IAW-1:0] in_addr;
    logic [T-1:0]   in_wdata;
    logic           start;
    logic           busy;
    logic           done;
    logic           err;
    logic [RAW-1:0] res_addr;
    logic [T-1:0]   res_rdata;

    conv_frame_host_if #(.T(T)) xy ();

    conv_frame_host #(
        .N (N),
        .M (M),
        .T (T)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_we     (in_we),
        .in_addr   (in_addr),
        .in_wdata  (in_wdata),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .res_addr  (res_addr),
        .res_rdata (res_rdata),
        .xy        (xy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [T-1:0] in_mem [N];
    logic         err_model;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [T-1:0] result_word(input int k);
        return T'(3 * k - 40);
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"},    32'(busy),       32'd0);
        check_eq({tag, "_done"},    32'(done),       32'd0);
        check_eq({tag, "_err"},     32'(err),        32'd0);
        check_eq({tag, "_x_valid"}, 32'(xy.x_valid), 32'd0);
        check_eq({tag, "_y_ready"}, 32'(xy.y_ready), 32'd0);
    endtask

    task automatic load_frame(input bit rnd);
        for (int i = 0; i < int'(N); i++) begin
            in_we    = 1'b1;
            in_addr  = IAW'(i);
            in_wdata = rnd ? T'($urandom) : T'(i);
            in_mem[i] = in_wdata;
            tick();
        end
        in_we = 1'b0;
    endtask

    // xmode: 0 ready always, 1 toggling, 2 random.
    // ymode: 0 valid always, 1 random valid and hold, 2 five-cycle hold at first result.
    task automatic run_frame(input int xmode, input int ymode, input bit guards);
        int  cyc;
        int  xsent;
        int  ysent;
        int  hold_left;
        bit  fin;
        bit  stop;
        bit  exp_xv;
        bit  exp_yr;
        start = 1'b1;
        tick();
        start     = 1'b0;
        err_model = 1'b0;
        cyc       = 1;
        xsent     = 0;
        ysent     = 0;
        hold_left = 5;
        fin       = 1'b0;
        stop      = 1'b0;
        while (!stop && cyc < BUDGET) begin
            case (xmode)
                0:       xy.x_ready = 1'b1;
                1:       xy.x_ready = (cyc % 2 == 0);
                default: xy.x_ready = 1'($urandom_range(0, 1));
            endcase
            start = 1'b0;
            in_we = 1'b0;
            if (guards && (cyc == 10 || cyc == 40)) start = 1'b1;
            if (guards && xsent == int'(N) && ysent == 2) begin
                in_we    = 1'b1;
                in_addr  = IAW'(3);
                in_wdata = 16'h7FFF;
            end
            xy.y_valid = 1'b0;
            xy.y_hold  = 1'b0;
            if (xsent == int'(N) && ysent < int'(L)) begin
                xy.y_data = result_word(ysent);
                case (ymode)
                    0: xy.y_valid = 1'b1;
                    1: begin
                        xy.y_valid = 1'($urandom_range(0, 1));
                        xy.y_hold  = ($urandom_range(0, 3) == 0);
                    end
                    default: begin
                        xy.y_valid = 1'b1;
                        if (hold_left > 0) begin
                            xy.y_hold = 1'b1;
                            hold_left--;
                        end
                    end
                endcase
            end
            #3;
            exp_xv = (cyc >= 2) && (xsent < int'(N));
            exp_yr = (cyc >= 2) && !fin && !xy.y_hold;
            check_eq("busy",    32'(busy),       32'(!fin));
            check_eq("done",    32'(done),       32'(fin));
            check_eq("err",     32'(err),        32'(err_model));
            check_eq("x_valid", 32'(xy.x_valid), 32'(exp_xv));
            check_eq("y_ready", 32'(xy.y_ready), 32'(exp_yr));
            if (exp_xv) begin
                check_eq("x_data", 32'(xy.x_data), 32'(in_mem[xsent]));
            end
            if (fin) begin
                stop = 1'b1;
            end else begin
                if (exp_xv && xy.x_ready) begin
                    if (xmode == 0) check_eq("x_gapless", 32'(cyc), 32'(xsent + 2));
                    xsent++;
                end
                if (xy.y_valid && exp_yr) begin
                    ysent++;
                    if (ysent == int'(L)) fin = 1'b1;
                end
            end
            tick();
            cyc++;
        end
        start      = 1'b0;
        in_we      = 1'b0;
        xy.x_ready = 1'b0;
        xy.y_valid = 1'b0;
        xy.y_hold  = 1'b0;
        check_eq("frame_complete", 32'(stop), 32'd1);
        check_eq("x_count", 32'(xsent), 32'(N));
        for (int k = 0; k < int'(L); k++) begin
            res_addr = RAW'(k);
            tick();
            check_eq("res_rdata", 32'(res_rdata), 32'(result_word(k)));
        end
        check_eq("done_after", 32'(done), 32'd1);
    endtask

    task automatic err_test();
        xy.y_valid = 1'b1;
        xy.y_data  = '0;
        tick();
        xy.y_valid = 1'b0;
        err_model  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_eq("err_sticky", 32'(err), 32'(err_model));
            tick();
        end
    endtask

    task automatic abort_frame();
        start = 1'b1;
        tick();
        start      = 1'b0;
        xy.x_ready = 1'b1;
        repeat (20) tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #3;
        check_idle_outputs("abort");
        @(posedge clk);
        #1;
        xy.x_ready = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        in_we      = 1'b0;
        in_addr    = '0;
        in_wdata   = '0;
        start      = 1'b0;
        res_addr   = '0;
        xy.x_ready = 1'b0;
        xy.y_valid = 1'b0;
        xy.y_data  = '0;
        xy.y_hold  = 1'b0;
        err_model  = 1'b0;
        repeat (3) tick();
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();
        check_idle_outputs("post_reset");

        load_frame(1'b0);
        run_frame(0, 0, 1'b0);
        run_frame(1, 1, 1'b0);
        run_frame(2, 2, 1'b1);
        run_frame(2, 1, 1'b0);

        err_test();
        load_frame(1'b1);
        check_eq("err_after_load", 32'(err), 32'd1);
        run_frame(2, 1, 1'b0);

        abort_frame();
        run_frame(0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_frame_host.md
# conv_frame_host

Host-side initiator for the streaming 1-D convolution accelerators (conv_N_M_T_P family). It buffers one N-sample input frame written by the system, streams it out on the x valid/ready channel and collects the L = N−M+1 results returned on the y valid/ready channel into a result buffer. It then signals completion and exposes the results through a random-access read port. It sits between the system bus and one convolution block and is the far end of both of that block's stream interfaces.

## Interface
- N, 96, input frame length (samples)
- M, 65, filter length; only used to derive L = N−M+1
- T, 16, sample width (signed)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_we  in  1  write strobe for the input buffer
- in_addr  in  clog2(N)  input buffer write address
- in_wdata  in  T  input sample
- start  in  1  begin one frame transfer
- busy  out  1  frame in progress
- done  out  1  level; last frame completed
- err  out  1  sticky; unexpected y_valid outside a frame
- res_addr  in  clog2(L)  result read address
- res_rdata  out  T  result word, 1-cycle synchronous read
- x_data  out  T  sample to convolution block
- x_valid  out  1  x_data valid
- x_ready  in  1  convolution block accepts x
- y_data  in  T  result from convolution block
- y_valid  in  1  y_data valid
- y_ready  out  1  host accepts y
- y_hold  in  1  backpressure; forces y_ready low

## Operation
- States: IDLE, PRIME, SEND, RECV, DONE.
- IDLE/DONE + start → PRIME. Counters are cleared, done=0, err=0, and input buffer address 0 is read.
- PRIME → SEND unconditionally.
- SEND: x_valid=1 and x_data = the input buffer read output. The x handshake (fire) is x_valid && x_ready.
  - Read address = fire ? xcnt+1 : xcnt, which gives zero-bubble streaming.
  - On a fire with xcnt==N−1 → RECV.
- y_ready = (state==SEND || state==RECV) && !y_hold. On y_valid && y_ready: res_buf[ycnt] ← y_data, ycnt++.
- RECV: on the y fire with ycnt==L−1 → DONE.
- busy = state ∈ {PRIME, SEND, RECV}. done = (state==DONE).
- start while busy is ignored. in_we while busy is ignored; in_we in IDLE/DONE writes in_buf.
- err is set when y_valid=1 in IDLE, PRIME or DONE; cleared by start or reset.
- Results are readable in any state. An entry not yet written in the current frame returns its previous content.
- Arithmetic: none on data. Samples pass bit-exact. Counters are xcnt (clog2(N)+1 bits) and ycnt (clog2(L)+1 bits), with no wrap inside a frame.

## Timing
- Reset (synchronous): state=IDLE, all counters 0, busy=0, done=0, err=0, x_valid=0, y_ready=0.
  - x_data and res_rdata follow RAM contents, which are not reset.
  - Reset mid-frame aborts immediately; the next start re-streams from in_buf[0].
- start sampled at edge k → PRIME during cycle k+1 → x_valid=1 with x_data=in_buf[0] from cycle k+2.
- With x_ready held at 1, N consecutive x fires occur in cycles k+2 … k+N+1.
- While x_valid && !x_ready, x_data is held stable.
- A result fire at edge j is readable from res_rdata at edge j+2 (write at j, read address presented at j+1).
- Final y fire at edge j → done=1 and busy=0 from cycle j+1.
- Both RAMs: read-during-write to the same address returns old data.

## Structure
- Package conv_host_pkg holds:
  - the state enum type
  - functions for L and the address widths from N, M
- Sub-module conv_buf_ram: simple dual-port RAM (WIDTH, DEPTH), one write port and one synchronous read port. It is instantiated twice: as in_buf (N×T) and res_buf (L×T).

## Test plan
- Reset: assert reset 2 cycles mid-SEND → next cycle busy=0, done=0, err=0, x_valid=0, y_ready=0. A new start streams in_buf[0] first.
- Full frame: in_buf[i]=i, x_ready=1, sink model returns y[k]=3k−40 after the load.
  - Expect exactly 96 x fires with values 0..95, gapless from start+2.
  - Expect res_buf[k]=3k−40 for k=0..31, and done=1.
- x backpressure: x_ready toggles 1,0,1,0 → x_data constant whenever stalled; sequence 0..95 with no duplicates or skips.
- y backpressure: y_hold=1 for 5 cycles while y_valid=1 → y_ready=0 and no result write; the held word is stored after release.
- Guards:
  - start pulses during SEND → ignored.
  - in_we during RECV to addr 3 with value 0x7FFF → in_buf[3] unchanged.
  - Restart after DONE → done drops, a second frame completes.
- Error flag: y_valid=1 for one cycle in DONE → err=1 and stays set; the next start clears it.
